// File: rtl/grad_mag_pkg.sv
// rtl/grad_mag_pkg.sv - shared types, widths and direction threshold for grad_mag_pipe
package grad_mag_pkg;

   localparam int unsigned ModeWidth = 2;
   localparam int unsigned DirWidth  = 2;

   typedef enum logic [ModeWidth-1:0] {
      MAG_L1      = 2'd0,
      MAG_LINF    = 2'd1,
      MAG_MAXHALF = 2'd2,
      MAG_MAX38   = 2'd3
   } mode_e;

   typedef enum logic [DirWidth-1:0] {
      DIR_0   = 2'd0,
      DIR_45  = 2'd1,
      DIR_90  = 2'd2,
      DIR_135 = 2'd3
   } dir_e;

   // v * 0.4375, close to v * tan(22.5 deg)
   function automatic logic [31:0] thr(input logic [31:0] v);
      return (v >> 2) + (v >> 3) + (v >> 4);
   endfunction

endpackage

// File: rtl/grad_mag_stage.sv
// rtl/grad_mag_stage.sv - one valid/ready elastic pipeline register with optional data reset
module grad_mag_stage #(
   parameter int unsigned DataWidth = 8,
   parameter bit          ResetData = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [DataWidth-1:0] data_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [DataWidth-1:0] data_o
);

   assign ready_o = !valid_o || ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_o <= 1'b0;
      end else if (ready_o) begin
         valid_o <= valid_i;
      end
   end

   // data only moves on a real beat, so idle-cycle input values never reach data_o
   if (ResetData) begin : g_rst_data
      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            data_o <= '0;
         end else if (ready_o && valid_i) begin
            data_o <= data_i;
         end
      end
   end else begin : g_keep_data
      always_ff @(posedge clk_i) begin
         if (ready_o && valid_i) begin
            data_o <= data_i;
         end
      end
   end

endmodule

// File: rtl/grad_mag_pipe.sv
// rtl/grad_mag_pipe.sv - 3-stage elastic gradient magnitude (abs, sort, norm)
// GRAD_MAG_DIR_EN adds the quantised direction output dir_o
module grad_mag_pipe
   import grad_mag_pkg::*;
#(
   parameter int unsigned Width     = 14,
   parameter bit          ResetData = 1'b1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 valid_i,
   output logic                 ready_o,
   input  logic [Width-1:0]     gx_i,
   input  logic [Width-1:0]     gy_i,
   input  logic [ModeWidth-1:0] mode_i,
   output logic                 valid_o,
   input  logic                 ready_i,
   output logic [Width:0]       mag_o
`ifdef GRAD_MAG_DIR_EN
   ,
   output logic [DirWidth-1:0]  dir_o
`endif
);

   // the negation of the most negative value wraps to 2^(Width-1), which is exact as unsigned
   logic [Width-1:0] ax_d, ay_d;
   assign ax_d = gx_i[Width-1] ? -gx_i : gx_i;
   assign ay_d = gy_i[Width-1] ? -gy_i : gy_i;

`ifdef GRAD_MAG_DIR_EN
   localparam int unsigned S1W = 2*Width + ModeWidth + 2;
   localparam int unsigned S2W = 2*Width + ModeWidth + DirWidth;
   localparam int unsigned S3W = Width + 1 + DirWidth;
`else
   localparam int unsigned S1W = 2*Width + ModeWidth;
   localparam int unsigned S2W = 2*Width + ModeWidth;
   localparam int unsigned S3W = Width + 1;
`endif

   logic [S1W-1:0] s1_d, s1_q;
   logic [S2W-1:0] s2_d, s2_q;
   logic [S3W-1:0] s3_d, s3_q;
   logic           s1_valid, s1_ready, s2_valid, s2_ready;

   logic [Width-1:0]     s1_ax, s1_ay, s2_mx, s2_mn, mx_d, mn_d;
   logic [ModeWidth-1:0] s1_mode, s2_mode;
   logic [Width:0]       mx_e, mn_e, mag_d;

   assign mx_d = (s1_ax >= s1_ay) ? s1_ax : s1_ay;
   assign mn_d = (s1_ax >= s1_ay) ? s1_ay : s1_ax;
   assign mx_e = {1'b0, s2_mx};
   assign mn_e = {1'b0, s2_mn};

   always_comb begin
      mag_d = mx_e;
      case (mode_e'(s2_mode))
         MAG_L1:      mag_d = mx_e + mn_e;
         MAG_LINF:    mag_d = mx_e;
         MAG_MAXHALF: mag_d = mx_e + (mn_e >> 1);
         MAG_MAX38:   mag_d = mx_e + (mn_e >> 2) + (mn_e >> 3);
         default:     mag_d = mx_e;
      endcase
   end

`ifdef GRAD_MAG_DIR_EN
   logic                s1_sx, s1_sy;
   logic [DirWidth-1:0] s2_dir;
   dir_e                dir_d;

   // decided one stage early, from the unsorted magnitudes, then carried beside the norm
   always_comb begin
      dir_d = DIR_0;
      if (32'(s1_ay) <= thr(32'(s1_ax))) begin
         dir_d = DIR_0;
      end else if (32'(s1_ax) <= thr(32'(s1_ay))) begin
         dir_d = DIR_90;
      end else if (s1_sx == s1_sy) begin
         dir_d = DIR_45;
      end else begin
         dir_d = DIR_135;
      end
   end

   assign s1_d = {gx_i[Width-1], gy_i[Width-1], mode_i, ax_d, ay_d};
   assign {s1_sx, s1_sy, s1_mode, s1_ax, s1_ay} = s1_q;
   assign s2_d = {dir_d, s1_mode, mx_d, mn_d};
   assign {s2_dir, s2_mode, s2_mx, s2_mn} = s2_q;
   assign s3_d = {s2_dir, mag_d};
   assign {dir_o, mag_o} = s3_q;
`else
   assign s1_d = {mode_i, ax_d, ay_d};
   assign {s1_mode, s1_ax, s1_ay} = s1_q;
   assign s2_d = {s1_mode, mx_d, mn_d};
   assign {s2_mode, s2_mx, s2_mn} = s2_q;
   assign s3_d = mag_d;
   assign mag_o = s3_q;
`endif

   grad_mag_stage #(.DataWidth(S1W), .ResetData(ResetData)) u_s1 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(valid_i), .ready_o(ready_o), .data_i(s1_d),
      .valid_o(s1_valid), .ready_i(s1_ready), .data_o(s1_q)
   );

   grad_mag_stage #(.DataWidth(S2W), .ResetData(ResetData)) u_s2 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(s1_valid), .ready_o(s1_ready), .data_i(s2_d),
      .valid_o(s2_valid), .ready_i(s2_ready), .data_o(s2_q)
   );

   grad_mag_stage #(.DataWidth(S3W), .ResetData(ResetData)) u_s3 (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .valid_i(s2_valid), .ready_o(s2_ready), .data_i(s3_d),
      .valid_o(valid_o), .ready_i(ready_i), .data_o(s3_q)
   );

endmodule

// File: tb/tb_grad_mag_pipe.sv
// tb/tb_grad_mag_pipe.sv - scoreboard bench for grad_mag_pipe (with or without GRAD_MAG_DIR_EN)
module tb_grad_mag_pipe;
   import grad_mag_pkg::*;

   localparam int W = 14;

   logic         clk     = 1'b0;
   logic         rst_ni  = 1'b0;
   logic         valid_i = 1'b0;
   logic         ready_o;
   logic [W-1:0] gx_i    = '0;
   logic [W-1:0] gy_i    = '0;
   logic [1:0]   mode_i  = '0;
   logic         valid_o;
   logic         ready_i = 1'b1;
   logic [W:0]   mag_o;
`ifdef GRAD_MAG_DIR_EN
   logic [1:0]   dir_o;
`endif

   grad_mag_pipe #(.Width(W), .ResetData(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_ni),
      .valid_i(valid_i), .ready_o(ready_o),
      .gx_i(gx_i), .gy_i(gy_i), .mode_i(mode_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .mag_o(mag_o)
`ifdef GRAD_MAG_DIR_EN
      , .dir_o(dir_o)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int mag;
      int dir;
      int stamp;
      bit lat;
   } exp_t;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   n_checks  = 0;
   int   n_pass    = 0;
   bit   stall_req = 1'b0;
   bit   rand_rdy  = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint got, input longint want);
      n_checks++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, got, want, cyc);
   endtask

   function automatic int ref_mag(input int gx, input int gy, input int md);
      int ax = (gx < 0) ? -gx : gx;
      int ay = (gy < 0) ? -gy : gy;
      int hi = (ax > ay) ? ax : ay;
      int lo = (ax > ay) ? ay : ax;
      case (md)
         0:       return ax + ay;
         1:       return hi;
         2:       return hi + lo / 2;
         default: return hi + lo / 4 + lo / 8;
      endcase
   endfunction

   function automatic int ref_dir(input int gx, input int gy);
      int ax = (gx < 0) ? -gx : gx;
      int ay = (gy < 0) ? -gy : gy;
      if (ay <= int'(thr(32'(ax)))) return 0;
      if (ax <= int'(thr(32'(ay)))) return 2;
      return ((gx < 0) == (gy < 0)) ? 1 : 3;
   endfunction

   function automatic int rnd_grad();
      return int'($urandom_range(0, (1 << W) - 1)) - (1 << (W - 1));
   endfunction

   // downstream ready changes just after each rising edge
   always @(posedge clk) begin
      #2;
      if (stall_req)     ready_i = 1'b0;
      else if (rand_rdy) ready_i = ($urandom_range(0, 3) != 0);
      else               ready_i = 1'b1;
   end

   task automatic send(input int gx, input int gy, input int md, input bit lat);
      exp_t e;
      int   waits = 0;
      @(negedge clk);
      valid_i = 1'b1;
      gx_i    = W'(gx);
      gy_i    = W'(gy);
      mode_i  = 2'(md);
      while (!ready_o && waits < 500) begin
         @(negedge clk);
         waits++;
      end
      if (!ready_o) begin
         check("accept_timeout", ready_o, 1);
         valid_i = 1'b0;
         return;
      end
      e.mag   = ref_mag(gx, gy, md);
      e.dir   = ref_dir(gx, gy);
      e.stamp = cyc;
      e.lat   = lat;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      valid_i = 1'b0;
      gx_i    = W'($urandom);
      gy_i    = W'($urandom);
      mode_i  = 2'($urandom);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain", exp_q.size(), 0);
   endtask

   // monitor: pops the scoreboard on every output transfer and checks stalled outputs hold
   bit         held = 1'b0;
   logic [W:0] held_mag;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_ni) begin
         held = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", valid_o, 1);
            check("hold_mag", mag_o, held_mag);
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               check("mag", mag_o, e.mag);
`ifdef GRAD_MAG_DIR_EN
               check("dir", dir_o, e.dir);
`endif
               if (e.lat) check("latency", cyc - e.stamp, 3);
            end
         end
         held     = valid_o && !ready_i;
         held_mag = mag_o;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("reset_valid_o", valid_o, 0);
      check("reset_mag_o", mag_o, 0);
      check("reset_ready_o", ready_o, 1);
      @(negedge clk);
      rst_ni = 1'b1;

      send(-3, 4, 0, 1'b1);
      send(-8192, 8191, 1, 1'b1);
      send(-8192, -8192, 0, 1'b1);
      send(100, -60, 2, 1'b1);
      send(100, -60, 3, 1'b1);
      for (int m = 0; m < 4; m++) send(rnd_grad(), rnd_grad(), m, 1'b1);
      send(10, 2, 0, 1'b1);
      send(10, 10, 0, 1'b1);
      send(1, 20, 0, 1'b1);
      send(-10, 10, 0, 1'b1);
      send(0, 0, 0, 1'b1);
      drain();

      fork
         begin
            for (int i = 0; i < 10; i++)
               send(rnd_grad(), rnd_grad(), int'($urandom_range(0, 3)), 1'b0);
         end
         begin
            repeat (4) @(posedge clk);
            stall_req = 1'b1;
            repeat (4) @(posedge clk);
            @(negedge clk);
            check("stall_ready_o", ready_o, 0);
            stall_req = 1'b0;
         end
      join
      drain();

      send(rnd_grad(), rnd_grad(), 0, 1'b1);
      send(rnd_grad(), rnd_grad(), 1, 1'b1);
      send(rnd_grad(), rnd_grad(), 2, 1'b1);
      #2;
      rst_ni = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_valid_o", valid_o, 0);
      check("midreset_mag_o", mag_o, 0);
      @(posedge clk);
      @(negedge clk);
      rst_ni = 1'b1;
      send(-5, 12, 0, 1'b1);
      drain();

      rand_rdy = 1'b1;
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send(rnd_grad(), rnd_grad(), int'($urandom_range(0, 3)), 1'b0);
      end
      drain();
      rand_rdy = 1'b0;

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
